// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: port A (never stalls) beats port M (MDU handshake),
// with a one-entry hold buffer for displaced M results and a busy scoreboard for decode.
module regfile_wb_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] chk_rs,
    input  logic [ADDR_W-1:0] chk_rt,
    output logic              hazard,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              m_valid,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_data,
    output logic              m_ready,
    output logic              reg_we,
    output logic [ADDR_W-1:0] reg_W_addr,
    output logic [DATA_W-1:0] wdata,
    output logic [31:0]       busy_mask,
    output logic [CNT_W-1:0]  conflict_cnt
);

    typedef enum logic {HOLD_EMPTY, HOLD_FULL} hold_state_t;

    hold_state_t       r_state;
    logic [ADDR_W-1:0] r_hold_addr;
    logic [DATA_W-1:0] r_hold_data;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_src_m;
    logic [31:0]       r_busy;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_m_fire;
    logic              w_sel_valid;
    logic              w_sel_m;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic [31:0]       w_busy_nxt;

    assign m_ready  = !rst && (r_state == HOLD_EMPTY);
    assign w_m_fire = m_valid && m_ready;

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_m     = 1'b0;
        w_sel_addr  = '0;
        w_sel_data  = '0;
        if (a_valid) begin
            w_sel_valid = 1'b1;
            w_sel_addr  = a_addr;
            w_sel_data  = a_data;
        end else if (r_state == HOLD_FULL) begin
            w_sel_valid = 1'b1;
            w_sel_m     = 1'b1;
            w_sel_addr  = r_hold_addr;
            w_sel_data  = r_hold_data;
        end else if (w_m_fire) begin
            w_sel_valid = 1'b1;
            w_sel_m     = 1'b1;
            w_sel_addr  = m_addr;
            w_sel_data  = m_data;
        end
    end

    // Clear is applied before set so a same-cycle issue to the committing register wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_we && r_src_m)
            w_busy_nxt[r_addr] = 1'b0;
        if (issue_valid && (issue_rd != '0))
            w_busy_nxt[issue_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HOLD_EMPTY;
            r_hold_addr <= '0;
            r_hold_data <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_src_m     <= 1'b0;
            r_busy      <= '0;
            r_cnt       <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_we   <= w_sel_valid && (w_sel_addr != '0);
            if (w_sel_valid) begin
                r_addr  <= w_sel_addr;
                r_data  <= w_sel_data;
                r_src_m <= w_sel_m;
            end
            case (r_state)
                HOLD_EMPTY: begin
                    if (a_valid && w_m_fire) begin
                        r_state     <= HOLD_FULL;
                        r_hold_addr <= m_addr;
                        r_hold_data <= m_data;
                        if (r_cnt != '1)
                            r_cnt <= r_cnt + 1'b1;
                    end
                end
                HOLD_FULL: begin
                    if (!a_valid)
                        r_state <= HOLD_EMPTY;
                end
                default: r_state <= HOLD_EMPTY;
            endcase
        end
    end

    assign reg_we       = r_we;
    assign reg_W_addr   = r_addr;
    assign wdata        = r_data;
    assign busy_mask    = r_busy;
    assign conflict_cnt = r_cnt;
    assign hazard       = r_busy[chk_rs] | r_busy[chk_rt];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized bench for regfile_wb_arbiter against a queue-based reference model.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd, chk_rs, chk_rt;
    logic        hazard;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        m_valid;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_ready;
    logic        reg_we;
    logic [4:0]  reg_W_addr;
    logic [31:0] wdata;
    logic [31:0] busy_mask;
    logic [15:0] conflict_cnt;

    regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .chk_rs(chk_rs), .chk_rt(chk_rt), .hazard(hazard),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
        .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready),
        .reg_we(reg_we), .reg_W_addr(reg_W_addr), .wdata(wdata),
        .busy_mask(busy_mask), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending M results as a queue, scoreboard as a bit set.
    typedef struct packed { logic [4:0] a; logic [31:0] d; } wr_t;
    wr_t         hq[$];
    bit   [31:0] mdl_busy = '0;
    int          mdl_cnt = 0;
    bit          mdl_we = 0, mdl_src_m = 0;
    bit   [4:0]  mdl_addr = '0;
    bit   [31:0] mdl_data = '0;

    task automatic step(input bit r, input bit iv, input bit [4:0] ird,
                        input bit [4:0] rs, input bit [4:0] rt,
                        input bit av, input bit [4:0] aa, input bit [31:0] ad,
                        input bit mv, input bit [4:0] ma, input bit [31:0] md);
        bit        exp_mr, fire, out_v, out_m;
        bit [4:0]  out_a;
        bit [31:0] out_d;
        bit [31:0] nb;
        wr_t       e;
        rst = r; issue_valid = iv; issue_rd = ird; chk_rs = rs; chk_rt = rt;
        a_valid = av; a_addr = aa; a_data = ad; m_valid = mv; m_addr = ma; m_data = md;
        #1;
        exp_mr = !r && (hq.size() == 0);
        check("m_ready", m_ready, exp_mr);
        check("hazard", hazard, mdl_busy[rs] | mdl_busy[rt]);
        fire = mv && exp_mr;

        nb = mdl_busy;
        if (mdl_we && mdl_src_m) nb[mdl_addr] = 0;
        if (iv && ird != 0) nb[ird] = 1;

        out_v = 0; out_m = 0; out_a = 0; out_d = 0;
        if (av) begin
            out_v = 1; out_a = aa; out_d = ad;
            if (fire) begin
                hq.push_back('{a: ma, d: md});
                if (mdl_cnt < 65535) mdl_cnt++;
            end
        end else if (hq.size() > 0) begin
            e = hq.pop_front();
            out_v = 1; out_m = 1; out_a = e.a; out_d = e.d;
        end else if (fire) begin
            out_v = 1; out_m = 1; out_a = ma; out_d = md;
        end
        mdl_we = out_v && (out_a != 0);
        if (out_v) begin
            mdl_addr = out_a; mdl_data = out_d; mdl_src_m = out_m;
        end
        mdl_busy = nb;
        if (r) begin
            hq.delete();
            mdl_busy = '0; mdl_cnt = 0; mdl_we = 0; mdl_src_m = 0;
            mdl_addr = '0; mdl_data = '0;
        end

        @(posedge clk); #1;
        check("reg_we", reg_we, mdl_we);
        check("busy_mask", busy_mask, mdl_busy);
        check("conflict_cnt", conflict_cnt, mdl_cnt);
        if (mdl_we || r) begin
            check("reg_W_addr", reg_W_addr, mdl_addr);
            check("wdata", wdata, mdl_data);
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_busy", busy_mask, 32'h0);
        check("rst_we", reg_we, 1'b0);

        // Single A write, visible for exactly one cycle
        step(0, 0, 0, 0, 0, 1, 5'd3, 32'h11, 0, 0, 0);
        check("a_we", reg_we, 1'b1);
        check("a_data", wdata, 32'h11);
        idle();
        check("a_we_drop", reg_we, 1'b0);

        // Issue to r8, M commit clears it one cycle after the write
        step(0, 1, 5'd8, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 5'd8, 0, 0, 0, 0, 1, 5'd8, 32'hDEAD);
        check("m_wdata", wdata, 32'hDEAD);
        check("hz_during_commit", hazard, 1'b1);
        step(0, 0, 0, 5'd8, 0, 0, 0, 0, 0, 0, 0);
        check("hz_after_commit", hazard, 1'b0);

        // Conflict, then starvation with A held for four cycles
        step(0, 0, 0, 0, 0, 1, 5'd2, 32'hA, 1, 5'd5, 32'hB);
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 0, 0, 1, 5'(10 + i), 32'(i), 1, 5'd7, 32'hF);
        check("starve_ready", m_ready, 1'b0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("held_addr", reg_W_addr, 5'd5);
        check("held_data", wdata, 32'hB);
        check("conflict_one", conflict_cnt, 16'd1);

        // Address 0 from M and issue to r0
        step(0, 1, 5'd0, 0, 0, 0, 0, 0, 1, 5'd0, 32'h55);
        check("addr0_we", reg_we, 1'b0);

        // Reset with hold full and r8 busy
        step(0, 1, 5'd8, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 5'd4, 32'h4, 1, 5'd9, 32'h9);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            idle();
            check("post_rst_we", reg_we, 1'b0);
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit [4:0] ra, rm;
            ra = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            rm = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 2) == 0, 5'($urandom), 5'($urandom), 5'($urandom),
                 $urandom_range(0, 1) == 1, ra, $urandom,
                 $urandom_range(0, 2) != 0, rm, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 32x32 register file.
- Arbitrates between two writeback sources:
  - A: single-cycle ALU/load path; never stalls.
  - M: multi-cycle multiply/divide unit (MDU); valid/ready handshake.
- Holds at most one deferred M result in a hold buffer.
- Keeps a busy scoreboard of registers with outstanding MDU results; decode uses it for read-after-write hazard stalls.

Parameters:
ADDR_W, 5, register address width (32 registers)
DATA_W, 32, register data width
CNT_W, 16, width of the conflict counter

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
issue_valid  in  1  decode issues an MDU instruction this cycle
issue_rd  in  ADDR_W  destination register of the issued MDU instruction
chk_rs  in  ADDR_W  first source register checked by decode
chk_rt  in  ADDR_W  second source register checked by decode
hazard  out  1  chk_rs or chk_rt is busy
a_valid  in  1  port A writeback request
a_addr  in  ADDR_W  port A destination
a_data  in  DATA_W  port A data
m_valid  in  1  port M writeback request
m_addr  in  ADDR_W  port M destination
m_data  in  DATA_W  port M data
m_ready  out  1  port M accepted when m_valid && m_ready
reg_we  out  1  register file write enable
reg_W_addr  out  ADDR_W  register file write address
wdata  out  DATA_W  register file write data
busy_mask  out  32  scoreboard; bit i set = register i awaiting an MDU result
conflict_cnt  out  CNT_W  saturating count of M results diverted to the hold buffer

Behaviour:
- Reset: the clock is clk. Reset is synchronous and active-high, named rst. On rst at a clk edge:
  - reg_we=0, reg_W_addr=0, wdata=0.
  - busy_mask=0, conflict_cnt=0.
  - Hold buffer emptied; its contents are discarded.
  - Mid-operation reset drops any pending or held write.
- m_ready = !rst && hold buffer empty. Combinational from state only; never depends on a_valid.
- m_fire = m_valid && m_ready.
- Write-port outputs are registered: a request in cycle N appears on reg_we/reg_W_addr/wdata in cycle N+1, for exactly one cycle.
- Selection each cycle, first match wins:
  1. a_valid: output A. If m_fire in the same cycle, M goes into the hold buffer and conflict_cnt increments, saturating at all-ones.
  2. Hold buffer full: output the hold buffer; it becomes empty.
  3. m_fire: output M directly.
  4. Otherwise: reg_we=0 next cycle; reg_W_addr and wdata hold their previous values.
- Hold-buffer state machine:
  - EMPTY to FULL on a_valid && m_fire.
  - FULL to EMPTY when !a_valid.
  - FULL stays FULL while a_valid is high; starvation of M is allowed because port A has absolute priority.
- Address 0: a selected request with address 0 is consumed (port A accepted, or M handshaken/drained) but produces reg_we=0 in its output cycle and has no scoreboard effect.
- Each output cycle records whether its source was M (direct or via the hold buffer); this tags scoreboard clears.
- Scoreboard set: issue_valid && issue_rd!=0 sets busy_mask[issue_rd] at the clk edge.
- Scoreboard clear: busy_mask[reg_W_addr] is cleared at the clk edge that ends a cycle with reg_we=1 and source M. The bit is therefore still 1 during the cycle in which the register file write is committing.
- Simultaneous set and clear of the same register: set wins.
- Issue to an already-busy register: bit stays 1 and clears on the first M commit to that address. Preventing this is the decoder's job.
- Port A writes never change busy_mask, even to a busy register.
- busy_mask[0] is constantly 0.
- hazard = busy_mask[chk_rs] | busy_mask[chk_rt], combinational. Register 0 never raises hazard.

Test Plan:
- After reset: busy_mask=0, m_ready=1, reg_we=0. Then a_valid=1, a_addr=3, a_data=0x11 in cycle 1 -> reg_we=1, reg_W_addr=3, wdata=0x11 in cycle 2 only.
- Issue and hazard: issue_valid with issue_rd=8, then chk_rs=8 -> hazard=1. M writes addr 8, data 0xDEAD -> reg_we=1 next cycle with hazard still 1 that cycle; hazard=0 the cycle after and busy_mask[8]=0.
- Conflict: a_valid (addr 2, 0xA) and m_valid (addr 5, 0xB) in the same cycle -> cycle+1 writes 2/0xA with m_ready=0; cycle+2 writes 5/0xB; conflict_cnt=1; m_ready=1 again in cycle+2.
- Starvation: hold full and a_valid held high for 4 cycles -> four A writes, m_ready=0 throughout; the held M write appears the cycle after a_valid drops.
- Address 0: M writes addr 0 -> handshake completes, reg_we stays 0. Issue to rd=0 -> busy_mask unchanged.
- Reset mid-operation: hold full and busy_mask[8]=1, assert rst for one cycle -> hold discarded, busy_mask=0, conflict_cnt=0, no write appears afterwards.
